// File: rtl/sram_sp_init.sv
// Single-port synchronous SRAM that clears itself to INIT_VAL after reset.
// Reads return after one cycle, or two when OUT_REG adds an output stage.
module sram_sp_init #(
    parameter int                 DATA_W   = 8,
    parameter int                 ADDR_W   = 8,
    parameter logic [DATA_W-1:0]  INIT_VAL = {DATA_W{1'b0}},
    parameter bit                 OUT_REG  = 1'b0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CS,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              RD_VALID,
    output logic              BUSY,
    output logic              REJECT
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   clr_cnt_r;
    logic                busy_r;
    logic                reject_r;

    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_s;
    logic                rd_en_s;

    logic [DATA_W-1:0]   mem_r [DEPTH];
    logic [DATA_W-1:0]   rd_data_r;
    logic                rd_valid_r;

    // Clear/idle state machine with registered BUSY and REJECT
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= {ADDR_W{1'b0}};
            busy_r    <= 1'b1;
            reject_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    reject_r <= CS;
                    // terminal compare on the last word so the counter never wraps early
                    if (clr_cnt_r == LAST_ADDR) begin
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                        clr_cnt_r <= {ADDR_W{1'b0}};
                    end else begin
                        clr_cnt_r <= clr_cnt_r + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    reject_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_cnt_r <= {ADDR_W{1'b0}};
                    busy_r    <= 1'b1;
                    reject_r  <= 1'b0;
                end
            endcase
        end
    end

    // Select the single array port between the clear engine and user traffic
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = ADDRESS;
        mem_wdata_s = DATA_IN;
        rd_en_s     = 1'b0;
        if (!RST_N) begin
            mem_we_s = 1'b0;
            rd_en_s  = 1'b0;
        end else if (state_r == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = clr_cnt_r;
            mem_wdata_s = INIT_VAL;
        end else if (CS) begin
            mem_we_s = WE;
            rd_en_s  = ~WE;
        end else begin
            mem_we_s = 1'b0;
            rd_en_s  = 1'b0;
        end
    end

    // Storage array, deliberately not reset
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            mem_r[mem_addr_s] <= mem_wdata_s;
        end
    end

    // First read stage; data holds between reads so the output is never X after reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rd_data_r  <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_en_s;
            if (rd_en_s) begin
                rd_data_r <= mem_r[ADDRESS];
            end
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic [DATA_W-1:0] out_data_r;
            logic              out_valid_r;

            // Optional output stage, flushed by reset together with the first stage
            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    out_data_r  <= {DATA_W{1'b0}};
                    out_valid_r <= 1'b0;
                end else begin
                    out_valid_r <= rd_valid_r;
                    if (rd_valid_r) begin
                        out_data_r <= rd_data_r;
                    end
                end
            end

            assign DATA_OUT = out_data_r;
            assign RD_VALID = out_valid_r;
        end else begin : g_no_out_reg
            assign DATA_OUT = rd_data_r;
            assign RD_VALID = rd_valid_r;
        end
    endgenerate

    assign BUSY   = busy_r;
    assign REJECT = reject_r;

endmodule
